// File: rtl/c_compression_size_engine_if.sv
// Algorithm encoding plus the request/result handshake bundle between the
// cache data array (master) and the compression size engine (slave).
package c_compression_pkg;
    typedef enum logic [2:0] {
        ALGO_NO   = 3'd0,
        ALGO_ZERO = 3'd1,
        ALGO_FVC  = 3'd2,
        ALGO_BDI  = 3'd3,
        ALGO_FPC  = 3'd4,
        ALGO_BEST = 3'd5
    } t_CompressionAlgorithm;
endpackage

interface c_compression_size_engine_if #(
    parameter int LINE_BYTES = 64,
    parameter int SIZE_W     = $clog2(LINE_BYTES + 1)
);
    import c_compression_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic [8*LINE_BYTES-1:0]   in_line;
    t_CompressionAlgorithm     in_algo;
    logic                      out_valid;
    logic                      out_ready;
    logic [SIZE_W-1:0]         out_size;
    logic                      out_err;

    modport master (
        output in_valid, in_line, in_algo, out_ready,
        input  in_ready, out_valid, out_size, out_err
    );

    modport slave (
        input  in_valid, in_line, in_algo, out_ready,
        output in_ready, out_valid, out_size, out_err
    );
endinterface

// File: rtl/c_compression_size_engine.sv
// Multi-beat engine returning the compressed size of one cache line under
// NO/ZERO/FVC/BDI/FPC/BEST; the result is held until the consumer takes it.
module c_compression_size_engine
    import c_compression_pkg::*;
#(
    parameter int LINE_BYTES = 64,
    parameter int BEAT_BYTES = 8,
    parameter int SIZE_W     = $clog2(LINE_BYTES + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    c_compression_size_engine_if.slave  io
);
    localparam int NBEATS   = LINE_BYTES / BEAT_BYTES;
    localparam int BEAT_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int BEAT_DW  = 8 * BEAT_BYTES;
    localparam int BEAT_SH  = $clog2(BEAT_DW);
    localparam int ACC_W    = SIZE_W + 2;
    localparam int NPAIR    = 6;
    localparam int PAIR_B [NPAIR] = '{8, 8, 8, 4, 4, 2};
    localparam int PAIR_D [NPAIR] = '{1, 2, 4, 1, 2, 1};
    localparam int FPC_OVH  = (3 * (LINE_BYTES / 4) + 7) / 8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SCAN   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    localparam logic [BEAT_SH-1:0] BEAT_SH_ZERO = '0;

    // True when v, taken mod 2^w_bits, is a sign-extension of its low n_bits.
    function automatic logic sext_fits(input logic [63:0] v, input int w_bits, input int n_bits);
        logic [63:0] mask;
        logic [63:0] t;
        mask = (w_bits >= 64) ? '1 : ((64'd1 << w_bits) - 64'd1);
        t    = (v + (64'd1 << (n_bits - 1))) & mask;
        return (t >> n_bits) == 64'd0;
    endfunction

    function automatic logic [2:0] fpc_cost(input logic [31:0] w);
        if (w == 32'd0 || sext_fits({32'd0, w}, 32, 8))      return 3'd1;
        else if (sext_fits({32'd0, w}, 32, 16))               return 3'd2;
        else if (w[15:0] == 16'd0)                            return 3'd2;
        else if (sext_fits({48'd0, w[15:0]}, 16, 8) &&
                 sext_fits({48'd0, w[31:16]}, 16, 8))         return 3'd2;
        else if (w[7:0] == w[15:8] && w[15:8] == w[23:16] &&
                 w[23:16] == w[31:24])                        return 3'd1;
        else                                                  return 3'd4;
    endfunction

    logic [1:0]              state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [8*LINE_BYTES-1:0] line_q, line_d;
    logic [2:0]              algo_q, algo_d;
    logic                    zero_q, zero_d;
    logic                    same8_q, same8_d;
    logic [NPAIR-1:0]        fit_q, fit_d;
    logic [ACC_W-1:0]        fpc_sum_q, fpc_sum_d;
    logic                    out_valid_q, out_valid_d;
    logic [SIZE_W-1:0]       out_size_q, out_size_d;
    logic                    out_err_q, out_err_d;

    logic [BEAT_DW-1:0]      beat_data;
    logic                    beat_zero;
    logic                    beat_same8;
    logic [NPAIR-1:0]        beat_fit;
    logic [ACC_W-1:0]        beat_fpc;

    logic [ACC_W-1:0]        bdi_size;
    logic [ACC_W-1:0]        fpc_raw;
    logic [ACC_W-1:0]        fpc_size;
    logic [ACC_W-1:0]        result_size;
    logic                    result_err;

    // Per-beat contribution; every element is compared against element 0 of the line.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update so no latch is inferred.
        beat_data  = BEAT_DW'(line_q >> {beat_q, BEAT_SH_ZERO});
        beat_zero  = (beat_data == '0);
        beat_same8 = 1'b1;
        beat_fit   = '1;
        beat_fpc   = '0;
        for (int e = 0; e < BEAT_BYTES / 8; e++) begin
            if (64'(beat_data >> (64 * e)) != line_q[63:0]) beat_same8 = 1'b0;
        end
        for (int p = 0; p < NPAIR; p++) begin
            for (int e = 0; e < BEAT_BYTES / PAIR_B[p]; e++) begin
                if (!sext_fits(64'(beat_data >> (8 * PAIR_B[p] * e)) - line_q[63:0],
                               8 * PAIR_B[p], 8 * PAIR_D[p]))
                    beat_fit[p] = 1'b0;
            end
        end
        for (int w = 0; w < BEAT_BYTES / 4; w++) begin
            beat_fpc = beat_fpc + ACC_W'(fpc_cost(32'(beat_data >> (32 * w))));
        end
    end

    always_comb begin
        bdi_size = ACC_W'(LINE_BYTES);
        if (zero_q) bdi_size = ACC_W'(1);
        if (same8_q && ACC_W'(8) < bdi_size) bdi_size = ACC_W'(8);
        for (int p = 0; p < NPAIR; p++) begin
            if (fit_q[p] && ACC_W'(PAIR_B[p] + (LINE_BYTES / PAIR_B[p]) * PAIR_D[p]) < bdi_size)
                bdi_size = ACC_W'(PAIR_B[p] + (LINE_BYTES / PAIR_B[p]) * PAIR_D[p]);
        end
        fpc_raw  = fpc_sum_q + ACC_W'(FPC_OVH);
        fpc_size = (fpc_raw > ACC_W'(LINE_BYTES)) ? ACC_W'(LINE_BYTES) : fpc_raw;

        result_err = 1'b0;
        case (algo_q)
            ALGO_NO:   result_size = ACC_W'(LINE_BYTES);
            ALGO_ZERO: result_size = zero_q ? ACC_W'(1) : ACC_W'(LINE_BYTES);
            ALGO_FVC:  result_size = same8_q ? ACC_W'(8) : ACC_W'(LINE_BYTES);
            ALGO_BDI:  result_size = bdi_size;
            ALGO_FPC:  result_size = fpc_size;
            ALGO_BEST: result_size = (fpc_size < bdi_size) ? fpc_size : bdi_size;
            default: begin
                result_size = ACC_W'(LINE_BYTES);
                result_err  = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        line_d      = line_q;
        algo_d      = algo_q;
        zero_d      = zero_q;
        same8_d     = same8_q;
        fit_d       = fit_q;
        fpc_sum_d   = fpc_sum_q;
        out_valid_d = out_valid_q;
        out_size_d  = out_size_q;
        out_err_d   = out_err_q;
        case (state_q)
            S_IDLE: begin
                if (io.in_valid) begin
                    line_d    = io.in_line;
                    algo_d    = io.in_algo;
                    zero_d    = 1'b1;
                    same8_d   = 1'b1;
                    fit_d     = '1;
                    fpc_sum_d = '0;
                    beat_d    = '0;
                    state_d   = S_SCAN;
                end
            end
            S_SCAN: begin
                zero_d    = zero_q & beat_zero;
                same8_d   = same8_q & beat_same8;
                fit_d     = fit_q & beat_fit;
                fpc_sum_d = fpc_sum_q + beat_fpc;
                beat_d    = beat_q + 1'b1;
                if (beat_q == BEAT_W'(NBEATS - 1)) begin
                    beat_d  = '0;
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                out_size_d = SIZE_W'(result_size);
                out_err_d  = result_err;
                state_d    = S_HOLD;
            end
            S_HOLD: begin
                // out_valid is itself a flop, so it rises one cycle after HOLD is entered.
                if (out_valid_q && io.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            zero_q      <= 1'b0;
            same8_q     <= 1'b0;
            fit_q       <= '0;
            fpc_sum_q   <= '0;
            out_valid_q <= 1'b0;
            out_size_q  <= SIZE_W'(LINE_BYTES);
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            zero_q      <= zero_d;
            same8_q     <= same8_d;
            fit_q       <= fit_d;
            fpc_sum_q   <= fpc_sum_d;
            out_valid_q <= out_valid_d;
            out_size_q  <= out_size_d;
            out_err_q   <= out_err_d;
        end
    end

    // NOTE: the captured line and algorithm are payload, always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        line_q <= line_d;
        algo_q <= algo_d;
    end

    assign io.in_ready  = (state_q == S_IDLE);
    assign io.out_valid = out_valid_q;
    assign io.out_size  = out_size_q;
    assign io.out_err   = out_err_q;
endmodule

// File: tb/tb_c_compression_size_engine.sv
// Randomized and directed bench for c_compression_size_engine, compared
// against an arithmetic reference model of the size rules.
module tb_c_compression_size_engine;
    import c_compression_pkg::*;

    localparam int LB = 64;
    localparam int BB = 8;
    localparam int SW = $clog2(LB + 1);
    localparam int LW = 8 * LB;
    localparam int LAT = LB / BB + 2;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    c_compression_size_engine_if #(.LINE_BYTES(LB), .SIZE_W(SW)) io ();

    c_compression_size_engine #(.LINE_BYTES(LB), .BEAT_BYTES(BB), .SIZE_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Signed difference of element i and element 0, both bs bytes wide, mod 2^(8*bs).
    function automatic longint sdiff(input logic [LW-1:0] line, input int bs, input int i);
        logic [63:0] a;
        logic [63:0] b;
        a = 64'(line >> (8 * bs * i));
        b = line[63:0];
        case (bs)
            8:       return longint'(a - b);
            4:       return longint'(int'(a[31:0] - b[31:0]));
            default: return longint'(shortint'(a[15:0] - b[15:0]));
        endcase
    endfunction

    function automatic int ref_fpc_cost(input logic [31:0] w);
        int      s;
        shortint lo;
        shortint hi;
        s  = int'(w);
        lo = shortint'(w[15:0]);
        hi = shortint'(w[31:16]);
        if (w == 32'd0)                                      return 1;
        if (s >= -128 && s <= 127)                           return 1;
        if (s >= -32768 && s <= 32767)                       return 2;
        if (w[15:0] == 16'd0)                                return 2;
        if (lo >= -128 && lo <= 127 && hi >= -128 && hi <= 127) return 2;
        if (w[7:0] == w[15:8] && w[7:0] == w[23:16] && w[7:0] == w[31:24]) return 1;
        return 4;
    endfunction

    function automatic int ref_size(input logic [LW-1:0] line, input logic [2:0] algo, output bit err);
        int     bs [6] = '{8, 8, 8, 4, 4, 2};
        int     ds [6] = '{1, 2, 4, 1, 2, 1};
        bit     zero;
        bit     same8;
        bit     ok;
        int     bdi;
        int     fpc;
        longint lim;
        longint d;
        zero  = (line == '0);
        same8 = 1'b1;
        for (int i = 0; i < LB / 8; i++)
            if (64'(line >> (64 * i)) != line[63:0]) same8 = 1'b0;
        bdi = LB;
        if (zero) bdi = 1;
        if (same8 && 8 < bdi) bdi = 8;
        for (int p = 0; p < 6; p++) begin
            ok  = 1'b1;
            lim = longint'(1) << (8 * ds[p] - 1);
            for (int i = 0; i < LB / bs[p]; i++) begin
                d = sdiff(line, bs[p], i);
                if (d < -lim || d >= lim) ok = 1'b0;
            end
            if (ok && bs[p] + (LB / bs[p]) * ds[p] < bdi) bdi = bs[p] + (LB / bs[p]) * ds[p];
        end
        fpc = (3 * (LB / 4) + 7) / 8;
        for (int w = 0; w < LB / 4; w++) fpc += ref_fpc_cost(32'(line >> (32 * w)));
        if (fpc > LB) fpc = LB;
        err = 1'b0;
        case (algo)
            ALGO_NO:   return LB;
            ALGO_ZERO: return zero ? 1 : LB;
            ALGO_FVC:  return same8 ? 8 : LB;
            ALGO_BDI:  return bdi;
            ALGO_FPC:  return fpc;
            ALGO_BEST: return (fpc < bdi) ? fpc : bdi;
            default: begin
                err = 1'b1;
                return LB;
            end
        endcase
    endfunction

    function automatic logic [LW-1:0] rand_line(input int kind);
        logic [LW-1:0] l;
        logic [63:0]   b;
        logic [63:0]   mag;
        logic [31:0]   r;
        b = {$urandom, $urandom};
        for (int i = 0; i < LB / 4; i++) l[32*i +: 32] = $urandom;
        case (kind)
            1: l = '0;
            2: begin
                mag = 64'd1 << $urandom_range(4, 34);
                for (int i = 0; i < LB / 8; i++)
                    l[64*i +: 64] = b + (({$urandom, $urandom} & (mag - 64'd1)) - (mag >> 1));
            end
            3: for (int i = 0; i < LB / 4; i++)
                l[32*i +: 32] = b[31:0] + 32'($urandom_range(0, 600)) - 32'd300;
            4: for (int i = 0; i < LB / 8; i++) l[64*i +: 64] = b;
            5: for (int i = 0; i < LB / 4; i++) begin
                r = $urandom;
                case ($urandom_range(0, 5))
                    0: l[32*i +: 32] = 32'd0;
                    1: l[32*i +: 32] = {{24{r[7]}}, r[7:0]};
                    2: l[32*i +: 32] = {{16{r[15]}}, r[15:0]};
                    3: l[32*i +: 32] = {r[31:16], 16'h0};
                    4: l[32*i +: 32] = {{8{r[23]}}, r[23:16], {8{r[7]}}, r[7:0]};
                    default: l[32*i +: 32] = {4{r[7:0]}};
                endcase
            end
            6: for (int i = 0; i < LB / 2; i++)
                l[16*i +: 16] = b[15:0] + 16'($urandom_range(0, 300)) - 16'd150;
            default: ;
        endcase
        return l;
    endfunction

    // One request: accept, latency, result, optional back-pressure, release.
    task automatic run_req(input string tag, input logic [LW-1:0] line, input logic [2:0] algo,
                           input int hold, input int exp_size, input bit exp_err);
        int lat;
        @(negedge clk);
        check({tag, ".in_ready"}, io.in_ready, 1);
        io.in_valid  = 1'b1;
        io.in_line   = line;
        io.in_algo   = t_CompressionAlgorithm'(algo);
        io.out_ready = 1'b0;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        io.in_line  = rand_line(0);
        lat = 0;
        while (io.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".latency"}, lat, LAT);
        check({tag, ".size"}, io.out_size, exp_size);
        check({tag, ".err"}, io.out_err, exp_err);
        io.in_valid = 1'b1;
        io.in_line  = rand_line(0);
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            #1;
            check({tag, ".hold_valid"}, io.out_valid, 1);
            check({tag, ".hold_size"}, io.out_size, exp_size);
            check({tag, ".hold_ready"}, io.in_ready, 0);
        end
        @(negedge clk);
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        @(posedge clk);
        #1;
        io.out_ready = 1'b0;
        check({tag, ".drop_valid"}, io.out_valid, 0);
        check({tag, ".back_idle"}, io.in_ready, 1);
    endtask

    initial begin
        logic [LW-1:0] zl, seq, rep, hard, line;
        logic [2:0]    algo;
        int            exp;
        bit            err;
        bit            seen;

        rst          = 1'b1;
        io.in_valid  = 1'b0;
        io.in_line   = '0;
        io.in_algo   = ALGO_NO;
        io.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", io.in_ready, 1);
        check("rst.out_valid", io.out_valid, 0);
        check("rst.out_size", io.out_size, LB);
        check("rst.out_err", io.out_err, 0);
        @(negedge clk);
        rst = 1'b0;

        zl = '0;
        for (int i = 0; i < LB / 8; i++) seq[64*i +: 64] = 64'h1000 + 64'(i);
        for (int i = 0; i < LB / 8; i++) rep[64*i +: 64] = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < LB / 4; i++) hard[32*i +: 32] = {24'h123456, 8'($urandom) | 8'h01};

        run_req("zero.zero", zl, ALGO_ZERO, 0, 1, 0);
        run_req("zero.fpc",  zl, ALGO_FPC,  0, 22, 0);
        run_req("zero.best", zl, ALGO_BEST, 0, 1, 0);
        run_req("seq.bdi",   seq, ALGO_BDI,  0, 16, 0);
        run_req("seq.fpc",   seq, ALGO_FPC,  0, 30, 0);
        run_req("seq.best",  seq, ALGO_BEST, 0, 16, 0);
        run_req("rep.fvc",   rep, ALGO_FVC,  0, 8, 0);
        run_req("rep.bdi",   rep, ALGO_BDI,  0, 8, 0);
        run_req("hard.fpc",  hard, ALGO_FPC, 0, 64, 0);
        run_req("bp.bdi",    seq, ALGO_BDI,  5, 16, 0);

        // Abort: reset sampled on the 4th SCAN cycle must suppress the result.
        @(negedge clk);
        io.in_valid = 1'b1;
        io.in_line  = seq;
        io.in_algo  = ALGO_BDI;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort.in_ready", io.in_ready, 1);
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (io.out_valid === 1'b1) seen = 1'b1;
        end
        check("abort.no_valid", seen, 0);
        run_req("after_abort", rep, ALGO_FVC, 0, 8, 0);
        run_req("illegal", seq, 3'd6, 0, LB, 1);

        for (int n = 0; n < 40; n++) begin
            line = rand_line($urandom_range(0, 6));
            algo = 3'($urandom_range(0, 7));
            exp  = ref_size(line, algo, err);
            run_req($sformatf("rand%0d", n), line, algo, $urandom_range(0, 3), exp, err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
